alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Decoder-to-ALU sequencer: buffers decoded instructions in a FIFO, issues them one at a
// time to an asynchronous two-phase ALU, and holds each result until writeback takes it.
module alu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_op1,
  input  logic [31:0] dec_op2,
  input  logic [31:0] dec_op3,
  input  logic [31:0] dec_op4,
  input  logic [3:0]  dec_type,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [31:0] alu_op3,
  output logic [31:0] alu_op4,
  output logic [3:0]  alu_type,
  output logic        alu_data_valid,
  output logic        alu_trigger,
  input  logic        alu_ready,
  input  logic [31:0] alu_res,
  input  logic [31:0] alu_cpsr,
  input  logic        alu_w,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [31:0] wb_cpsr,
  output logic        wb_write,
  output logic [1:0]  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic [31:0] op4;
    logic [3:0]  typ;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;
  logic [2:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic            timeout;
  logic            rdy_meta, rdy_s;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign dec_ready = reset & ~full;
  assign push      = dec_valid & dec_ready;
  assign head      = mem[rd_ptr];
  assign timeout   = (wait_cnt == CW'(TIMEOUT));

  // The entry stays queued while in flight; it leaves on completion, timeout or rejection.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty && (head.typ != 4'd0);
      WAIT_LO: pop = timeout;
      WAIT_HI: pop = timeout || rdy_s;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op1: dec_op1, op2: dec_op2, op3: dec_op3, op4: dec_op4, typ: dec_type};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // alu_ready comes from another timing domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= alu_ready;
      rdy_s    <= rdy_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      alu_op1        <= '0;
      alu_op2        <= '0;
      alu_op3        <= '0;
      alu_op4        <= '0;
      alu_type       <= '0;
      alu_data_valid <= 1'b0;
      alu_trigger    <= 1'b0;
      wb_valid       <= 1'b0;
      wb_result      <= '0;
      wb_cpsr        <= '0;
      wb_write       <= 1'b0;
      err            <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          if (head.typ != 4'd0) begin
            err[1] <= 1'b1;
          end else begin
            alu_op1  <= head.op1;
            alu_op2  <= head.op2;
            alu_op3  <= head.op3;
            alu_op4  <= head.op4;
            alu_type <= head.typ;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          alu_data_valid <= 1'b1;
          alu_trigger    <= ~alu_trigger;
          wait_cnt       <= '0;
          state          <= WAIT_LO;
        end
        WAIT_LO, WAIT_HI: begin
          if (timeout) begin
            err[0]         <= 1'b1;
            alu_data_valid <= 1'b0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT_LO) begin
              if (!rdy_s) state <= WAIT_HI;
            end else if (rdy_s) begin
              wb_result      <= alu_res;
              wb_cpsr        <= alu_cpsr;
              wb_write       <= alu_w;
              wb_valid       <= 1'b1;
              alu_data_valid <= 1'b0;
              state          <= DONE;
            end
          end
        end
        DONE: if (wb_ready) begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
